ps2_kbd_decoder: RTL and testbench
==================================

Name: ps2_kbd_decoder

Overview:
- Sits directly downstream of the PS/2 receiver (ps2_rx) and consumes its byte stream (rx_done_tick plus the 8-bit data byte).
- Strips the E0 (extended) and F0 (break) prefix bytes and tracks shift-key state.
- Produces complete key events: scan code, extended flag, make/break flag and ASCII for a basic key set.
- Events are buffered in a small first-word-fall-through FIFO that the host logic drains with a read strobe.

Parameters:
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk  input  1  system clock; the same clock that drives ps2_rx.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- rx_done_tick  input  1  one-cycle strobe from ps2_rx; the byte on din is valid in that cycle.
- din  input  8  received byte; connects to ps2_rx dout.
- key_rd  input  1  pop strobe; removes the head event when key_valid=1.
- key_valid  output  1  FIFO not empty; the head event is on the key_* outputs.
- key_code  output  8  head event scan code (prefixes removed).
- key_ext  output  1  head event was E0-prefixed.
- key_brk  output  1  head event is a break (release); 0 means make.
- key_ascii  output  8  head event ASCII code; 0x00 if the key is unmapped.
- shift_held  output  1  left or right shift is currently held.
- fifo_overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0 at a clock edge): FSM goes to IDLE, FIFO is emptied, shift state is cleared.
  - Reset values: key_valid=0, shift_held=0, fifo_overflow=0.
  - key_code/key_ext/key_brk/key_ascii read 0 while the FIFO is empty.
- Bytes are processed only on edges where rx_done_tick=1. din is ignored otherwise.
- Prefix FSM, one transition per received byte:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Filtered bytes -> IDLE, no event. Filtered set: 00, AA, EE, FA, FC, FD, FE, FF (BAT, echo, ACK, errors).
    - Any other byte -> emit make event (ext=0), stay in IDLE.
  - EXT:
    - F0 -> EXTBRK.
    - E0 -> EXT.
    - Any other byte -> emit make (ext=1) -> IDLE.
  - BRK:
    - F0 -> BRK.
    - E0 -> EXT (resync, the pending break is discarded).
    - Any other byte -> emit break (ext=0) -> IDLE.
  - EXTBRK:
    - E0 or F0 -> IDLE, no event.
    - Any other byte -> emit break (ext=1) -> IDLE.
- Event latency: the event is written on the same edge that samples the terminating byte. key_valid and the head outputs update from that edge, i.e. visible in the following cycle.
- Shift tracking: non-extended code 12 (left shift) and 59 (right shift).
  - One held bit per key: set on make, cleared on break.
  - shift_held = OR of the two bits; updates on the same edge as the event.
- ASCII mapping (non-extended events only; extended events always give 00):
  - Letters map to lowercase 0x61-0x7A, or uppercase 0x41-0x5A when shift is held.
  - Letter codes:
    - A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A
    - N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A
  - Digits map to 0x30-0x39 regardless of shift: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46.
  - Space 29 -> 0x20; Enter 5A -> 0x0D; Backspace 66 -> 0x08; all others -> 0x00.
  - ASCII is computed with the shift state from before the current byte's update, so shift keys themselves map to 0x00.
  - Break events carry the same ASCII as the matching make.
- FIFO:
  - First-word fall-through; head event is always on the key_* outputs while key_valid=1.
  - key_rd with key_valid=0 is ignored.
  - Push when full: the new event is dropped and fifo_overflow is set. fifo_overflow stays set until reset.
  - Simultaneous push and pop when full: both take effect, no overflow, count is unchanged.
  - Simultaneous push and pop when empty: the pop is ignored, the push succeeds.
- Read and write pointers wrap modulo the FIFO depth. Full/empty is decided with an extra pointer bit or an occupancy counter.

Test Plan:
- Reset, then rx bytes 1C -> next cycle key_valid=1, code=1C, ext=0, brk=0, ascii=0x61; after key_rd, key_valid=0.
- Bytes 12,1C,F0,1C,F0,12 -> four events:
  - 12 make, ascii 00;
  - 1C make, ascii 0x41;
  - 1C break, ascii 0x41;
  - 12 break.
  - shift_held rises with the first event and falls with the fourth.
- Bytes E0,75,E0,F0,75 -> two events: code=75 ext=1 brk=0, then code=75 ext=1 brk=1; ascii=00 for both.
- With FIFO_AW=2 and no reads, makes 16,1E,26,25,2E -> 4 events stored, fifo_overflow=1, 2E dropped; reads return 31,32,33,34 ASCII in order.
- Bytes F0, then reset=0 for one edge, then 1C -> a single make event for 1C (the break prefix is cleared), fifo_overflow=0.
- Bytes FA, AA, 00 -> no events, FSM stays in IDLE; a following 29 gives a make with ascii=0x20.

Source files
------------

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder
//   Turns the raw PS/2 scan-code byte stream from ps2_rx into complete key events
//   (scan code, extended flag, make/break flag, ASCII) and buffers them in a small
//   first-word-fall-through FIFO drained by the host with a read strobe.
//
// Ports:
//   clk           system clock (same clock as ps2_rx)
//   reset         synchronous active-low reset
//   rx_done_tick  one-cycle strobe, din valid in that cycle
//   din           received byte from ps2_rx
//   key_rd        pop strobe for the head event (ignored when empty)
//   key_valid     FIFO not empty; head event is on key_*
//   key_code      head event scan code, prefixes stripped
//   key_ext       head event was E0-prefixed
//   key_brk       head event is a release
//   key_ascii     head event ASCII, 0x00 when unmapped
//   shift_held    left or right shift currently held
//   fifo_overflow sticky: an event was dropped on a full FIFO
module ps2_kbd_decoder #(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] din,
    input  logic       key_rd,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic [7:0] key_ascii,
    output logic       shift_held,
    output logic       fifo_overflow
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExt    = 2'd1;
    localparam logic [1:0] StBrk    = 2'd2;
    localparam logic [1:0] StExtBrk = 2'd3;

    localparam logic [7:0] CodeExt    = 8'hE0;
    localparam logic [7:0] CodeBrk    = 8'hF0;
    localparam logic [7:0] CodeLShift = 8'h12;
    localparam logic [7:0] CodeRShift = 8'h59;

    // Non-extended scan code to ASCII; letters are uppercased when shift is held.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] letter;
        logic [7:0] other;
        letter = 8'h00;
        other  = 8'h00;
        case (code)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            8'h45: other = 8'h30;   8'h16: other = 8'h31;   8'h1E: other = 8'h32;
            8'h26: other = 8'h33;   8'h25: other = 8'h34;   8'h2E: other = 8'h35;
            8'h36: other = 8'h36;   8'h3D: other = 8'h37;   8'h3E: other = 8'h38;
            8'h46: other = 8'h39;
            8'h29: other = 8'h20;   8'h5A: other = 8'h0D;   8'h66: other = 8'h08;
            default: ;
        endcase
        if (letter != 8'h00) begin
            return shift ? (letter - 8'h20) : letter;
        end
        return other;
    endfunction

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic       ev_valid, ev_ext, ev_brk;
    logic       filtered;

    always_comb begin
        unique case (din)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: filtered = 1'b1;
            default:                                                filtered = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                StIdle: begin
                    if (din == CodeExt)      state_d = StExt;
                    else if (din == CodeBrk) state_d = StBrk;
                    else if (!filtered)      ev_valid = 1'b1;
                end
                StExt: begin
                    if (din == CodeBrk) begin
                        state_d = StExtBrk;
                    end else if (din != CodeExt) begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StBrk: begin
                    // E0 after F0 is out of sequence: drop the break and resync.
                    if (din == CodeExt) begin
                        state_d = StExt;
                    end else if (din != CodeBrk) begin
                        ev_valid = 1'b1;
                        ev_brk   = 1'b1;
                        state_d  = StIdle;
                    end
                end
                default: begin // StExtBrk
                    state_d = StIdle;
                    if (din != CodeExt && din != CodeBrk) begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                        ev_brk   = 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shift tracking
    // ------------------------------------------------------------------
    logic lshift_q, lshift_d;
    logic rshift_q, rshift_d;

    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        if (ev_valid && !ev_ext) begin
            if (din == CodeLShift) lshift_d = !ev_brk;
            if (din == CodeRShift) rshift_d = !ev_brk;
        end
    end

    assign shift_held = lshift_q | rshift_q;

    // ASCII uses the shift state before this byte, so shift keys map to 0x00.
    logic [7:0] ev_ascii;
    assign ev_ascii = ev_ext ? 8'h00 : scan_to_ascii(din, shift_held);

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through, extra pointer bit for full/empty)
    // ------------------------------------------------------------------
    logic [17:0]      mem_q [Depth];
    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
    logic             full, empty, pop, push;
    logic             overflow_q;
    logic [17:0]      head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop   = key_rd & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = ev_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ev_valid && full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {din, ev_ext, ev_brk, ev_ascii};
    end

    assign head          = empty ? 18'd0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign key_valid     = ~empty;
    assign key_code      = head[17:10];
    assign key_ext       = head[9];
    assign key_brk       = head[8];
    assign key_ascii     = head[7:0];
    assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
module tb_ps2_kbd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] din;
    logic       key_rd;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic [7:0] key_ascii;
    logic       shift_held;
    logic       fifo_overflow;

    int n_cmp = 0;
    int n_mis = 0;

    ps2_kbd_decoder #(.FIFO_AW(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .key_rd       (key_rd),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_brk      (key_brk),
        .key_ascii    (key_ascii),
        .shift_held   (shift_held),
        .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one cycle; returns at the negedge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        din          = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        din          = 8'h00;
    endtask

    task automatic pop();
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
    endtask

    // Check the head event, then pop it.
    task automatic chk_ev(input string tag, input logic [7:0] code, input logic ext,
                          input logic brk, input logic [7:0] ascii);
        chk1({tag, ".valid"}, key_valid, 1'b1);
        chk8({tag, ".code"},  key_code,  code);
        chk1({tag, ".ext"},   key_ext,   ext);
        chk1({tag, ".brk"},   key_brk,   brk);
        chk8({tag, ".ascii"}, key_ascii, ascii);
        pop();
    endtask

    initial begin
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        din          = 8'h00;
        key_rd       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state
        chk1("rst.valid", key_valid, 1'b0);
        chk1("rst.shift", shift_held, 1'b0);
        chk1("rst.ovf", fifo_overflow, 1'b0);
        chk8("rst.code", key_code, 8'h00);
        chk8("rst.ascii", key_ascii, 8'h00);

        // Single make, visible the cycle after the byte
        send(8'h1C);
        chk_ev("a_make", 8'h1C, 1'b0, 1'b0, 8'h61);
        chk1("a_empty", key_valid, 1'b0);

        // Left shift + A make/break
        send(8'h12);
        chk1("lsh.held", shift_held, 1'b1);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        chk1("lsh.held_pre", shift_held, 1'b1);
        send(8'h12);
        chk1("lsh.rel", shift_held, 1'b0);
        chk_ev("lsh_mk", 8'h12, 1'b0, 1'b0, 8'h00);
        chk_ev("A_mk", 8'h1C, 1'b0, 1'b0, 8'h41);
        chk_ev("A_brk", 8'h1C, 1'b0, 1'b1, 8'h41);
        chk_ev("lsh_brk", 8'h12, 1'b0, 1'b1, 8'h00);
        chk1("lsh.empty", key_valid, 1'b0);

        // Extended make/break
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk_ev("ext_mk", 8'h75, 1'b1, 1'b0, 8'h00);
        chk_ev("ext_brk", 8'h75, 1'b1, 1'b1, 8'h00);
        chk1("ext.empty", key_valid, 1'b0);

        // Overflow with no reads
        send(8'h16);
        send(8'h1E);
        send(8'h26);
        send(8'h25);
        chk1("ovf.pre", fifo_overflow, 1'b0);
        send(8'h2E);
        chk1("ovf.set", fifo_overflow, 1'b1);
        chk_ev("d1", 8'h16, 1'b0, 1'b0, 8'h31);
        chk_ev("d2", 8'h1E, 1'b0, 1'b0, 8'h32);
        chk_ev("d3", 8'h26, 1'b0, 1'b0, 8'h33);
        chk_ev("d4", 8'h25, 1'b0, 1'b0, 8'h34);
        chk1("ovf.empty", key_valid, 1'b0);
        chk1("ovf.sticky", fifo_overflow, 1'b1);

        // Reset clears a pending break prefix and the overflow flag
        send(8'hF0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk1("rst2.ovf", fifo_overflow, 1'b0);
        chk1("rst2.valid", key_valid, 1'b0);
        send(8'h1C);
        chk_ev("rst2_mk", 8'h1C, 1'b0, 1'b0, 8'h61);
        chk1("rst2.empty", key_valid, 1'b0);

        // Filtered bytes give no event
        send(8'hFA);
        send(8'hAA);
        send(8'h00);
        chk1("filt.valid", key_valid, 1'b0);
        send(8'h29);
        chk_ev("space", 8'h29, 1'b0, 1'b0, 8'h20);

        // Right shift uppercases; enter and backspace mapped
        send(8'h59);
        send(8'h32);
        send(8'hF0);
        send(8'h59);
        chk1("rsh.rel", shift_held, 1'b0);
        chk_ev("rsh_mk", 8'h59, 1'b0, 1'b0, 8'h00);
        chk_ev("B_mk", 8'h32, 1'b0, 1'b0, 8'h42);
        chk_ev("rsh_brk", 8'h59, 1'b0, 1'b1, 8'h00);
        send(8'h5A);
        send(8'h66);
        chk_ev("enter", 8'h5A, 1'b0, 1'b0, 8'h0D);
        chk_ev("bksp", 8'h66, 1'b0, 1'b0, 8'h08);

        // EXTBRK followed by a prefix returns to IDLE; BRK+E0 resyncs to EXT
        send(8'hE0);
        send(8'hF0);
        send(8'hE0);
        chk1("extbrk.none", key_valid, 1'b0);
        send(8'h1C);
        chk_ev("extbrk_after", 8'h1C, 1'b0, 1'b0, 8'h61);
        send(8'hF0);
        send(8'hE0);
        send(8'h1C);
        chk_ev("resync", 8'h1C, 1'b1, 1'b0, 8'h00);

        // Push and pop together while full: no overflow, both happen
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        @(negedge clk);
        rx_done_tick = 1'b1;
        din          = 8'h24;
        key_rd       = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        key_rd       = 1'b0;
        chk1("fpp.ovf", fifo_overflow, 1'b0);
        chk_ev("fpp1", 8'h32, 1'b0, 1'b0, 8'h62);
        chk_ev("fpp2", 8'h21, 1'b0, 1'b0, 8'h63);
        chk_ev("fpp3", 8'h23, 1'b0, 1'b0, 8'h64);
        chk_ev("fpp4", 8'h24, 1'b0, 1'b0, 8'h65);
        chk1("fpp.empty", key_valid, 1'b0);

        // Push and pop together while empty: pop ignored
        @(negedge clk);
        rx_done_tick = 1'b1;
        din          = 8'h2B;
        key_rd       = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        key_rd       = 1'b0;
        chk_ev("epp", 8'h2B, 1'b0, 1'b0, 8'h66);
        chk1("epp.empty", key_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
